rv_instruction_encoder: RTL and testbench
=========================================

Name: rv_instruction_encoder

Overview:
- Inverse of the instruction decoder: takes RV64IM instruction fields in decoded form and packs them into 32-bit instruction words.
- Checks immediate range and alignment for each format.
- Tags every output word with a byte address from an internal program counter.
- Feeds the instruction-memory preload path and self-test program generation.
- 2-stage valid/ready pipeline; 1 word/cycle sustained.

Parameters:
- BASE_ADDR, 64'h0, address assigned to the first word after reset.
- ADDR_SIZE, 64, width of out_addr and addr_load_value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- in_format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  instruction bits [6:0].
- in_funct3  input  3  instruction bits [14:12] (R/I/S/B).
- in_funct7  input  7  instruction bits [31:25] (R only).
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  64  sign-extended immediate value; for U format this is the full value, with low 12 bits zero.
- addr_load  input  1  load the address counter.
- addr_load_value  input  ADDR_SIZE  new address for the counter.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts the word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_SIZE  byte address of out_instr.
- out_err  output  1  range/format violation on this word.
- err_count  output  16  count of transferred words with out_err=1; saturates at 16'hFFFF.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0, both stages empty, in_ready=1 in the cycle after reset deasserts.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_instr, out_addr and out_err are held stable while out_valid && !out_ready.
- Stage 1 (S1):
  - Registers the fields.
  - Computes err:
    - format 6 or 7 → err=1.
    - I, S: in_imm must equal sign-extension of in_imm[11:0].
    - B: sign-extension of in_imm[12:0], and in_imm[0]=0.
    - U: in_imm[11:0]=0, and in_imm equals sign-extension of in_imm[31:0].
    - J: sign-extension of in_imm[20:0], and in_imm[0]=0.
    - R: in_imm ignored, never an error.
- Stage 2 (S2):
  - Packs the word per the base ISA layouts:
    - R: {funct7, rs2, rs1, funct3, rd, opcode}
    - I: {imm[11:0], rs1, funct3, rd, opcode}
    - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
    - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
    - U: {imm[31:12], rd, opcode}
    - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - On error the word is still packed from the truncated fields; illegal format produces 32'h0.
- Latency: input transfer in cycle N → out_valid in cycle N+2 when not stalled.
- Flow control:
  - in_ready = !S1.valid || !S2.valid || out_ready (stalls propagate).
  - No bubbles and no dropped or duplicated words under any out_ready pattern.
- Address counter:
  - out_addr holds the address of the word currently presented.
  - Increments by 4 on each output transfer; wraps modulo 2^ADDR_SIZE.
  - addr_load=1 sets the counter to addr_load_value for the next word.
  - If addr_load and an output transfer occur in the same cycle, the transferring word keeps its old address and load wins over the increment.
  - addr_load does not alter the in-flight word's displayed address until it transfers.
- err_count increments on an output transfer with out_err=1.
- reset mid-operation: both stages flushed, in-flight words lost, counter returns to BASE_ADDR.

Test Plan:
- I format, opcode 0010011, funct3 0, rd=1, rs1=0, imm=5 → out_instr=32'h00500093, out_addr=0, out_err=0, 2 cycles after input.
- S format, opcode 0100011, funct3 3, rs1=1, rs2=2, imm=8 → 32'h0020B423; B format, opcode 1100011, funct3 0, rs1=1, rs2=2, imm=-4 → 32'hFE208EE3; out_addr 0 then 4.
- J format, opcode 1101111, rd=1, imm=2048 → 32'h001000EF; U format, opcode 0110111, rd=5, imm=32'h12345000 → 32'h123452B7.
- I format, rd=1, imm=2048 → out_instr=32'h80000093, out_err=1, err_count=1; B format with imm=3 → out_err=1, err_count=2.
- Back-to-back stream of 8 words with out_ready toggling 1,0,0,1,...:
  - all 8 words emerge in order, addresses 0..28, no loss;
  - in_ready=0 only while both stages are full and out_ready=0.
- addr_load=1, value=64'h1000, in the same cycle as a transfer of the word at 8 → that word reports 8, next word 64'h1000; assert reset with 2 words in flight → out_valid=0 next cycle, next word at BASE_ADDR.

Source files
------------

// File: rtl/rv_instruction_encoder.sv
// rv_instruction_encoder: packs decoded RV64IM fields into 32-bit instruction
// words, checks immediate range/alignment per format and tags each word with
// a byte address taken from an internal, loadable program counter.
//
// Two register stages:
//   S1 holds the captured fields and the range-check result.
//   S2 holds the packed word, its error flag and its address.
//
// Handshake: a transfer happens on either side only when valid and ready are
// both high on a rising edge. in_ready depends combinationally on out_ready,
// so a stall propagates back in the same cycle. S2 holds out_instr, out_addr
// and out_err stable while out_valid && !out_ready.
module rv_instruction_encoder #(
    parameter int                   ADDR_SIZE = 64,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_format,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [63:0]          in_imm,
    input  logic                 addr_load,
    input  logic [ADDR_SIZE-1:0] addr_load_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic                 out_err,
    output logic [15:0]          err_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Stage 1 registers
    logic        s1_valid_q;
    logic [2:0]  s1_format_q;
    logic [6:0]  s1_opcode_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [31:0] s1_imm_q;
    logic        s1_err_q;
    logic        s1_err_d;

    // Stage 2 registers (drive the outputs directly)
    logic                 out_valid_q;
    logic [31:0]          out_instr_q;
    logic                 out_err_q;
    logic [ADDR_SIZE-1:0] out_addr_q;
    logic [31:0]          s2_instr_d;

    // Address the next word entering S2 will receive
    logic [ADDR_SIZE-1:0] next_addr_q;
    logic [ADDR_SIZE-1:0] addr_assign;
    logic [15:0]          err_count_q;

    logic s2_en;
    logic out_fire;

    assign out_fire    = out_valid_q && out_ready;
    assign s2_en       = !out_valid_q || out_ready;
    assign in_ready    = !s1_valid_q || s2_en;
    // A load in the same cycle a word enters S2 applies to that word.
    assign addr_assign = addr_load ? addr_load_value : next_addr_q;

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = out_addr_q;
    assign err_count = err_count_q;

    // Immediate range and alignment check on the incoming request
    always_comb begin
        s1_err_d = 1'b0;
        case (in_format)
            FMT_R:        s1_err_d = 1'b0;
            FMT_I, FMT_S: s1_err_d = (in_imm != {{52{in_imm[11]}}, in_imm[11:0]});
            FMT_B:        s1_err_d = (in_imm != {{51{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
            FMT_U:        s1_err_d = (in_imm[11:0] != 12'd0) ||
                                     (in_imm != {{32{in_imm[31]}}, in_imm[31:0]});
            FMT_J:        s1_err_d = (in_imm != {{43{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
            default:      s1_err_d = 1'b1;
        endcase
    end

    // Stage 1: capture fields and error flag whenever S1 can move
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_format_q <= in_format;
                s1_opcode_q <= in_opcode;
                s1_funct3_q <= in_funct3;
                s1_funct7_q <= in_funct7;
                s1_rd_q     <= in_rd;
                s1_rs1_q    <= in_rs1;
                s1_rs2_q    <= in_rs2;
                s1_imm_q    <= in_imm[31:0];
                s1_err_q    <= s1_err_d;
            end
        end
    end

    // Pack the S1 fields into the base ISA layout; illegal formats give zero
    always_comb begin
        s2_instr_d = 32'h0;
        case (s1_format_q)
            FMT_R: s2_instr_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_rd_q, s1_opcode_q};
            FMT_I: s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q,
                                 s1_rd_q, s1_opcode_q};
            FMT_S: s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_imm_q[4:0], s1_opcode_q};
            FMT_B: s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                                 s1_funct3_q, s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FMT_U: s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FMT_J: s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                                 s1_imm_q[19:12], s1_rd_q, s1_opcode_q};
            default: s2_instr_d = 32'h0;
        endcase
    end

    // Stage 2: load the packed word when S2 is empty or draining
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_instr_q <= s2_instr_d;
                out_err_q   <= s1_err_q;
            end
        end
    end

    // Address counter: presented word keeps its address, loads target the next
    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr_q  <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
        end else if (s2_en && s1_valid_q) begin
            out_addr_q  <= addr_assign;
            next_addr_q <= addr_assign + ADDR_SIZE'(4);
        end else if (addr_load) begin
            next_addr_q <= addr_load_value;
        end
    end

    // Saturating count of transferred words flagged with an error
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= 16'h0;
        end else if (out_fire && out_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_rv_instruction_encoder.sv
// Testbench for rv_instruction_encoder: directed cases with known encodings,
// boundary immediates, a stalled burst, address load/reset scenarios and a
// randomized stream, all checked against a behavioural model.
module tb_rv_instruction_encoder;

    localparam logic [63:0] BASE = 64'h0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_format;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [63:0] in_imm;
    logic        addr_load;
    logic [63:0] addr_load_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        out_err;
    logic [15:0] err_count;

    rv_instruction_encoder #(.ADDR_SIZE(64), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_format       (in_format),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_funct7       (in_funct7),
        .in_rd           (in_rd),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_imm          (in_imm),
        .addr_load       (addr_load),
        .addr_load_value (addr_load_value),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_addr        (out_addr),
        .out_err         (out_err),
        .err_count       (err_count)
    );

    // ---------------- scoreboard state ----------------
    // entry: [64:33] accept cycle, [32] err, [31:0] instr
    logic [64:0] exp_q[$];
    logic [63:0] m_addr;
    logic        m_pend;
    logic [63:0] m_pend_val;
    int          m_errcnt;
    int          cyc_n;
    int          checks;
    int          errors;
    logic        last_in_fire;
    int          out_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [2:0] fmt, input logic [63:0] imm);
        longint s;
        s = $signed(imm);
        case (fmt)
            3'd0:       return 1'b0;
            3'd1, 3'd2: return !(s >= -64'sd2048 && s <= 64'sd2047);
            3'd3:       return !(s >= -64'sd4096 && s <= 64'sd4095) || (imm % 2 != 0);
            3'd4:       return (imm % 4096 != 0) ||
                               !(s >= -64'sd2147483648 && s <= 64'sd2147483647);
            3'd5:       return !(s >= -64'sd1048576 && s <= 64'sd1048575) || (imm % 2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input longint unsigned op,
                                               input longint unsigned f3, input longint unsigned f7,
                                               input longint unsigned rd, input longint unsigned rs1,
                                               input longint unsigned rs2, input longint unsigned imm);
        longint unsigned w;
        case (fmt)
            3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: w = ((imm % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: w = (((imm / 32) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | ((imm % 32) << 7) | op;
            3'd3: w = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (f3 << 12) | (((imm / 2) % 16) << 8)
                      | (((imm / 2048) % 2) << 7) | op;
            3'd4: w = (((imm / 4096) % 1048576) << 12) | (rd << 7) | op;
            3'd5: w = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21)
                      | (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12)
                      | (rd << 7) | op;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic logic [63:0] rand_imm();
        logic [63:0] v;
        logic [31:0] r;
        longint      t;
        case ($urandom_range(0, 4))
            0: begin t = longint'($urandom_range(0, 8191)) - 4096; v = t; end
            1: begin t = longint'($urandom_range(0, 4194303)) - 2097152; v = t; end
            2: v = {$urandom, $urandom};
            3: begin
                r = $urandom;
                r[11:0] = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'h000;
                v = {{32{r[31]}}, r};
                if ($urandom_range(0, 5) == 0) v[45] = ~v[45];
            end
            default: begin
                t = longint'($urandom_range(0, 4095)) - 2048;
                v = t;
                if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
            end
        endcase
        return v;
    endfunction

    // ---------------- per-cycle check and model update ----------------
    task automatic step();
        logic [64:0] head;
        logic        exp_valid;
        #1;
        check("err_count", 64'(err_count), 64'(m_errcnt));
        check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
        exp_valid = 1'b0;
        head = '0;
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            exp_valid = (cyc_n >= int'(head[64:33]) + 2);
        end
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (out_valid && exp_q.size() != 0) begin
            check("out_instr", 64'(out_instr), 64'(head[31:0]));
            check("out_err", 64'(out_err), 64'(head[32]));
            check("out_addr", out_addr, m_addr);
        end
        if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() != 0) begin
                if (head[32] && m_errcnt < 65535) m_errcnt++;
                void'(exp_q.pop_front());
            end
            m_addr = addr_load ? addr_load_value : (m_pend ? m_pend_val : m_addr + 64'd4);
            m_pend = 1'b0;
        end else if (addr_load) begin
            if (out_valid) begin
                m_pend     = 1'b1;
                m_pend_val = addr_load_value;
            end else begin
                m_addr = addr_load_value;
            end
        end
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) begin
            exp_q.push_back({32'(cyc_n), ref_err(in_format, in_imm),
                             ref_encode(in_format, 64'(in_opcode), 64'(in_funct3), 64'(in_funct7),
                                        64'(in_rd), 64'(in_rs1), 64'(in_rs2), in_imm)});
        end
        cyc_n++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic r, input logic ld, input logic [63:0] ldv,
                         input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [63:0] imm);
        @(negedge clk);
        in_valid = v; out_ready = r; addr_load = ld; addr_load_value = ldv;
        in_format = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        step();
    endtask

    task automatic idle(input logic r);
        drive(1'b0, r, 1'b0, 64'h0, 3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 64'h0);
    endtask

    task automatic drive_rand(input logic v, input logic r, input logic ld, input logic [63:0] ldv);
        logic [2:0] fmt;
        fmt = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        drive(v, r, ld, ldv, fmt, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), rand_imm());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        m_addr = BASE; m_pend = 1'b0; m_pend_val = '0; m_errcnt = 0;
        step();
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            idle(mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- boundary immediates ----------------
    logic [2:0]  bnd_fmt[16] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                                 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd4, 3'd6, 3'd7};
    logic [63:0] bnd_imm[16] = '{64'd2047, -64'sd2048, -64'sd2049, 64'd2048,
                                 64'd4094, -64'sd4096, 64'd4096, 64'd4095,
                                 64'd1048574, -64'sd1048576, 64'd1048576,
                                 64'h7FFF_F000, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
                                 64'd0, 64'd4};

    // ---------------- main sequence ----------------
    initial begin
        int sent;
        int guard;
        logic [2:0] f;
        logic [63:0] im;
        checks = 0; errors = 0; cyc_n = 0; out_count = 0; last_in_fire = 1'b0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0;
        addr_load_value = '0; in_format = '0; in_opcode = '0; in_funct3 = '0;
        in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        do_reset();

        // I-type, 2-cycle latency
        drive(1, 1, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd5);
        idle(1);
        idle(1);
        check("tp_i_valid", 64'(out_valid), 64'd1);
        check("tp_i_instr", 64'(out_instr), 64'h00500093);
        check("tp_i_addr", out_addr, 64'd0);

        // S then B
        do_reset();
        drive(1, 1, 0, 0, 3'd2, 7'h23, 3'd3, 7'h0, 5'd0, 5'd1, 5'd2, 64'd8);
        drive(1, 1, 0, 0, 3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, -64'sd4);
        idle(1);
        check("tp_s_instr", 64'(out_instr), 64'h0020B423);
        check("tp_s_addr", out_addr, 64'd0);
        idle(1);
        check("tp_b_instr", 64'(out_instr), 64'hFE208EE3);
        check("tp_b_addr", out_addr, 64'd4);

        // J then U
        do_reset();
        drive(1, 1, 0, 0, 3'd5, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd2048);
        drive(1, 1, 0, 0, 3'd4, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 64'h12345000);
        idle(1);
        check("tp_j_instr", 64'(out_instr), 64'h001000EF);
        idle(1);
        check("tp_u_instr", 64'(out_instr), 64'h123452B7);

        // error words and err_count
        do_reset();
        drive(1, 1, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd2048);
        idle(1);
        idle(1);
        check("tp_ierr_instr", 64'(out_instr), 64'h80000093);
        check("tp_ierr_err", 64'(out_err), 64'd1);
        drive(1, 1, 0, 0, 3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 64'd3);
        check("tp_errcnt1", 64'(err_count), 64'd1);
        idle(1);
        idle(1);
        check("tp_berr_err", 64'(out_err), 64'd1);
        idle(1);
        check("tp_errcnt2", 64'(err_count), 64'd2);

        // boundary immediates, back-to-back
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, bnd_fmt[i], 7'h13, 3'd1, 7'h20, 5'd3, 5'd4, 5'd5, bnd_imm[i]);
        end
        drain(0);

        // 8-word burst, out_ready 1,0,0 repeating
        do_reset();
        out_count = 0; sent = 0; guard = 0;
        while (sent < 8 && guard < 100) begin
            f  = 3'($urandom_range(0, 5));
            im = rand_imm();
            last_in_fire = 1'b0;
            while (!last_in_fire && guard < 100) begin
                drive(1, (guard % 3) == 0, 0, 0, f, 7'h33, 3'd2, 7'h01, 5'(sent), 5'd7, 5'd9, im);
                guard++;
            end
            sent++;
        end
        while (exp_q.size() != 0 && guard < 200) begin
            idle((guard % 3) == 0);
            guard++;
        end
        check("burst_count", 64'(out_count), 64'd8);
        check("burst_addr_next", m_addr, 64'd32);

        // address load coinciding with transfer of the word at 8
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 1, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'(i), 5'd0, 5'd0, 64'(i));
        drive(0, 1, 1, 64'h1000, 3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 64'h0);
        check("ld_old_addr", out_addr, 64'd8);
        idle(1);
        check("ld_new_valid", 64'(out_valid), 64'd1);
        check("ld_new_addr", out_addr, 64'h1000);

        // reset with two words in flight
        drive(1, 0, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd1);
        drive(1, 0, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd2, 5'd0, 5'd0, 64'd2);
        do_reset();
        drive(1, 1, 0, 0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd3, 5'd0, 5'd0, 64'd3);
        idle(1);
        idle(1);
        check("rst_next_addr", out_addr, BASE);

        // randomized stream with stalls, loads (incl. near wrap) and a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 19) == 0)
                drive_rand(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), 1,
                           ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                       : {$urandom, $urandom} & ~64'h3);
            else
                drive_rand(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), 0, 0);
        end
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
